seg_decode: RTL and testbench

Seven-segment pattern decoder and change reporter: the receive-side counterpart of the board's segment display encoder. It samples eight active-low segment buses and filters each digit for stability. Each stable digit pattern is converted back to a 4-bit hex value. Every change of a stable digit is emitted as one event on a valid/ready stream. It sits between the display outputs and the self-check/scoreboard logic of the board harness.

---
 rtl/seg_pkg.sv | 64 ++++++
 rtl/seg_digit_filter.sv | 44 ++++
 rtl/seg_decode.sv | 94 +++++++++
 tb/tb_seg_decode.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment receive path: glyph table, segment bit
// positions and the glyph-to-hex decoder.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  // Bit positions within a segment bus (a is the MSB).
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] BLANK_RAW = 8'hFF;

  // Active-high a..g,dp codes with dp clear.
  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  localparam logic [15:0][7:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef struct packed {
    logic       err;
    logic [3:0] val;
  } glyph_dec_t;

  // Takes a raw active-low bus; anything outside the table (blank included) is err.
  function automatic glyph_dec_t decode_glyph(input logic [7:0] raw);
    logic [7:0] pat;
    glyph_dec_t res;
    pat         = ~raw;
    pat[SEG_DP] = 1'b0;
    res         = '{err: 1'b1, val: 4'd0};
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPHS[i]) begin
        res.err = 1'b0;
        res.val = i[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_digit_filter.sv
// Per-digit stability filter: tracks the last sample, counts identical repeats
// and flags a pending event when a new stable pattern differs from the last one reported.
module seg_digit_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       clr,
  output logic [7:0] rep,
  output logic       pend
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [7:0] smp, cnt, cnt_nxt;
  logic       same, fire;

  always_comb begin
    same    = (sample == smp);
    cnt_nxt = 8'd0;
    if (same) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
    fire    = same && (cnt_nxt == CNT_MAX) && (smp != rep);
  end

  // A fresh stable pattern wins over a same-edge grant so the newer value still gets reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp  <= BLANK_RAW;
      cnt  <= 8'd0;
      rep  <= BLANK_RAW;
      pend <= 1'b0;
    end else begin
      smp <= sample;
      cnt <= cnt_nxt;
      if (fire) rep <= smp;
      if (fire)     pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_decode.sv
// Seven-segment decoder and change reporter: eight filtered digits, round-robin
// arbitration into a single valid/ready event register. Optional: SEG_DECODE_DP_EN.
module seg_decode
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_seg0,
  input  logic [7:0] i_seg1,
  input  logic [7:0] i_seg2,
  input  logic [7:0] i_seg3,
  input  logic [7:0] i_seg4,
  input  logic [7:0] i_seg5,
  input  logic [7:0] i_seg6,
  input  logic [7:0] i_seg7,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [2:0] o_idx,
  output logic [3:0] o_val,
  output logic       o_err,
  output logic       o_dp
);

  logic [NUM_DIGITS-1:0][7:0] seg_raw, sample, rep;
  logic [NUM_DIGITS-1:0]      pend, clr;

  assign seg_raw = {i_seg7, i_seg6, i_seg5, i_seg4, i_seg3, i_seg2, i_seg1, i_seg0};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
`ifdef SEG_DECODE_DP_EN
    assign sample[g] = seg_raw[g];
`else
    // Forcing raw dp off keeps blank at 8'hFF, so idle digits never look changed.
    assign sample[g] = seg_raw[g] | 8'h01;
`endif
    seg_digit_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
      .clk    (clk),
      .rst    (rst),
      .sample (sample[g]),
      .clr    (clr[g]),
      .rep    (rep[g]),
      .pend   (pend[g])
    );
  end

  // ptr holds the first index to search: last grant + 1.
  logic [IDX_W-1:0] ptr, grant_idx, probe;
  logic             found, load;
  glyph_dec_t       dec;

  always_comb begin
    grant_idx = '0;
    probe     = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      probe = ptr + i[IDX_W-1:0];
      if (!found && pend[probe]) begin
        found     = 1'b1;
        grant_idx = probe;
      end
    end
  end

  assign load = (!o_valid || i_ready) && found;
  assign clr  = load ? (NUM_DIGITS'(1) << grant_idx) : '0;
  assign dec  = decode_glyph(rep[grant_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_val   <= '0;
      o_err   <= 1'b0;
      o_dp    <= 1'b0;
    end else if (load) begin
      ptr     <= grant_idx + 3'd1;
      o_valid <= 1'b1;
      o_idx   <= grant_idx;
      o_val   <= dec.val;
      o_err   <= dec.err;
`ifdef SEG_DECODE_DP_EN
      o_dp    <= ~rep[grant_idx][SEG_DP];
`else
      o_dp    <= 1'b0;
`endif
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_decode.sv
// Bench for seg_decode: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against an event-level model.
module tb_seg_decode;

  localparam int ST = 4;
`ifdef SEG_DECODE_DP_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] seg [8];
  logic       o_valid, o_err, o_dp;
  logic [2:0] o_idx;
  logic [3:0] o_val;

  seg_decode #(.STABLE_CYCLES(ST)) dut (
    .clk(clk), .rst(rst),
    .i_seg0(seg[0]), .i_seg1(seg[1]), .i_seg2(seg[2]), .i_seg3(seg[3]),
    .i_seg4(seg[4]), .i_seg5(seg[5]), .i_seg6(seg[6]), .i_seg7(seg[7]),
    .o_valid(o_valid), .i_ready(i_ready), .o_idx(o_idx), .o_val(o_val),
    .o_err(o_err), .o_dp(o_dp)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] gly [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Hex value of a raw active-low bus, or -1 when it is not a glyph.
  function automatic int glyph_val(input logic [7:0] raw);
    logic [7:0] p;
    int r;
    p = ~raw & 8'hFE;
    r = -1;
    for (int i = 0; i < 16; i++) if (gly[i] == p) r = i;
    return r;
  endfunction

  // Model: per digit, length of the current run of identical samples and the
  // last value reported; one output slot served round robin.
  logic [7:0] m_last [8];
  logic [7:0] m_rep  [8];
  int         m_run  [8];
  bit         m_pend [8];
  int         m_ptr, m_idx, m_val;
  bit         m_v, m_err, m_dp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 8; d++) begin
        m_last[d] = 8'hFF; m_rep[d] = 8'hFF; m_run[d] = 1; m_pend[d] = 0;
      end
      m_ptr = 0; m_v = 0; m_idx = 0; m_val = 0; m_err = 0; m_dp = 0;
    end else begin
      int g, v;
      logic [7:0] s;
      g = -1;
      for (int k = 0; k < 8; k++)
        if (g < 0 && m_pend[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
      if ((!m_v || i_ready) && g >= 0) begin
        v        = glyph_val(m_rep[g]);
        m_v      = 1;
        m_idx    = g;
        m_err    = (v < 0);
        m_val    = (v < 0) ? 0 : v;
        m_dp     = DP ? !m_rep[g][0] : 1'b0;
        m_pend[g] = 0;
        m_ptr    = (g + 1) % 8;
      end else if (i_ready) begin
        m_v = 0;
      end
      for (int d = 0; d < 8; d++) begin
        s = DP ? seg[d] : (seg[d] | 8'h01);
        if (s == m_last[d]) begin
          if (m_run[d] < 1000) m_run[d]++;
        end else begin
          m_run[d]  = 1;
          m_last[d] = s;
        end
        if (m_run[d] >= ST && s != m_rep[d]) begin
          m_rep[d]  = s;
          m_pend[d] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", o_valid, m_v);
      if (m_v) begin
        chk("idx", o_idx, m_idx);
        chk("val", o_val, m_val);
        chk("err", o_err, m_err);
        chk("dp",  o_dp,  m_dp);
      end
    end
  end

  typedef struct { int idx; int val; int err; int dp; int cyc; } ev_t;
  ev_t evq [$];
  int  cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && o_valid === 1'b1 && i_ready === 1'b1)
      evq.push_back('{int'(o_idx), int'(o_val), int'(o_err), int'(o_dp), cyc});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 8; d++) seg[d] = 8'hFF;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 8; d++) seg[d] = 8'hFF;

    // Reset state and idle blank digits.
    do_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_val", o_val, 0);
    chk("rst_err", o_err, 0);
    chk("rst_dp", o_dp, 0);
    tick(100);
    chk("idle_events", evq.size(), 0);

    // Single event and its latency.
    evq.delete();
    seg[3] = ~8'hDA;
    repeat (ST) @(posedge clk);
    #1 chk("lat_early", o_valid, 0);
    @(posedge clk);
    #1 chk("lat_valid", o_valid, 1);
    chk("lat_idx", o_idx, 3);
    chk("lat_val", o_val, 2);
    chk("lat_err", o_err, 0);
    tick(10);
    chk("single_cnt", evq.size(), 1);
    seg[3] = 8'hFF;
    tick(10);

    // Glitch shorter than the filter, then a long-enough hold.
    evq.delete();
    seg[0] = ~8'h60;
    tick(ST - 1);
    seg[0] = 8'hFF;
    tick(10);
    chk("glitch_cnt", evq.size(), 0);
    seg[0] = ~8'h60;
    tick(ST);
    seg[0] = 8'hFF;
    tick(12);
    chk("hold_cnt", evq.size(), 2);
    if (evq.size() >= 2) begin
      chk("hold_idx", evq[0].idx, 0);
      chk("hold_val", evq[0].val, 1);
      chk("hold_err", evq[0].err, 0);
      chk("blank_err", evq[1].err, 1);
    end

    // Backpressure and round-robin fairness.
    do_reset();
    i_ready = 1'b0;
    evq.delete();
    for (int d = 0; d < 8; d++) seg[d] = ~8'hFE;
    tick(20);
    chk("stall_valid", o_valid, 1);
    chk("stall_idx", o_idx, 0);
    i_ready = 1'b1;
    tick(12);
    chk("rr_cnt", evq.size(), 8);
    for (int i = 0; i < 8 && i < evq.size(); i++) begin
      chk("rr_idx", evq[i].idx, i);
      chk("rr_val", evq[i].val, 8);
      if (i > 0) chk("rr_b2b", evq[i].cyc - evq[i-1].cyc, 1);
    end

    // Overwrite while stalled, then an illegal glyph.
    do_reset();
    i_ready = 1'b0;
    seg[2] = ~8'h60;
    tick(8);
    seg[5] = ~8'h9C;
    tick(6);
    seg[5] = ~8'h8E;
    tick(6);
    evq.delete();
    i_ready = 1'b1;
    tick(6);
    chk("ovw_cnt", evq.size(), 2);
    if (evq.size() >= 2) begin
      chk("ovw_idx", evq[1].idx, 5);
      chk("ovw_val", evq[1].val, 15);
    end
    seg[6] = ~8'h02;
    tick(8);
    chk("err_cnt", evq.size(), 3);
    if (evq.size() >= 3) begin
      chk("err_idx", evq[2].idx, 6);
      chk("err_flag", evq[2].err, 1);
      chk("err_val", evq[2].val, 0);
    end

    // Decimal-point-only change.
    do_reset();
    seg[1] = ~8'h60;
    tick(10);
    evq.delete();
    seg[1] = ~8'h61;
    tick(10);
    chk("dp_cnt", evq.size(), DP ? 1 : 0);
    if (DP && evq.size() >= 1) begin
      chk("dp_flag", evq[0].dp, 1);
      chk("dp_val", evq[0].val, 1);
    end

    // Randomized traffic: glitches, holds, illegal bytes, random backpressure.
    do_reset();
    evq.delete();
    for (int c = 0; c < 3000; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < 8; d++) begin
        if ($urandom_range(0, 7) == 0) begin
          n = $urandom_range(0, 9);
          if (n < 7)       seg[d] = ~gly[$urandom_range(0, 15)] & {7'h7F, 1'($urandom_range(0, 1))};
          else if (n == 7) seg[d] = 8'hFF;
          else             seg[d] = 8'($urandom);
        end
      end
      tick(1);
    end
    i_ready = 1'b1;
    tick(20);
    chk("rand_activity", evq.size() > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
